// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: shared state enum, geometry derivations and index widths
package conv_sched_pkg;
  localparam int ROW_W = 6;
  localparam int IDX_W = 7;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_WRITE, S_DONE} state_t;

  function automatic int calc_oh(input int h, input int f);
    return h - f + 1;
  endfunction

  function automatic int calc_ow(input int w, input int f);
    return w - f + 1;
  endfunction

  function automatic int calc_nu(input int w, input int f);
    return calc_ow(w, f) / 2;
  endfunction

  function automatic int calc_run_len(input int d, input int f);
    return d * f * f + 2;
  endfunction
endpackage

// File: rtl/conv_sched_if.sv
// conv_sched_if: control and half-row handshake between scheduler and datapath
interface conv_sched_if;
  import conv_sched_pkg::*;
  logic             start;
  logic             abort;
  logic             out_ready;
  logic [ROW_W-1:0] row_number;
  logic [ROW_W-1:0] column;
  logic             cu_clear;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, out_ready,
    input  row_number, column, cu_clear, out_valid, out_idx, busy, done
  );

  modport slave (
    input  start, abort, out_ready,
    output row_number, column, cu_clear, out_valid, out_idx, busy, done
  );
endinterface

// File: rtl/conv_sched_cnt.sv
// conv_sched_cnt: run-phase cycle counter with synchronous load-to-zero and terminal flag
module conv_sched_cnt #(
  parameter int RUN_LEN = 27,
  parameter int CW      = $clog2(RUN_LEN + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic inc,
  output logic term
);
  localparam logic [CW-1:0] LAST = CW'(RUN_LEN - 1);

  logic [CW-1:0] r_cnt;

  // Count accumulation cycles; any non-run cycle parks the counter at zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (load) r_cnt <= '0;
    else if (inc) r_cnt <= r_cnt + 1'b1;

  assign term = r_cnt == LAST;
endmodule

// File: rtl/conv_sched.sv
// conv_sched: sequences conv units over output half-rows (clear, accumulate, write)
module conv_sched
  import conv_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
) (
  input  logic         clk,
  input  logic         reset,
  conv_sched_if.slave  bus
);
  localparam int OH      = calc_oh(H, F);
  localparam int OW      = calc_ow(W, F);
  localparam int NU      = calc_nu(W, F);
  localparam int RUN_LEN = calc_run_len(D, F);
  localparam logic [ROW_W-1:0] NU_COL   = ROW_W'(NU);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OH - 1);

  if (DATA_WIDTH < 1 || OW % 2 != 0 || OH > 64 || 2 * OH > 128) begin : g_bad_geom
    $error("conv_sched: unsupported geometry");
  end

  state_t           r_state;
  logic [ROW_W-1:0] r_row;
  logic [ROW_W-1:0] r_col;
  logic             r_cu_clear;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;
  logic             w_load;
  logic             w_term;

  assign w_load = (r_state != S_RUN) || bus.abort;

  conv_sched_cnt #(.RUN_LEN(RUN_LEN)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .inc   (r_state == S_RUN),
    .term  (w_term)
  );

  // Scheduler FSM; all outputs registered alongside the state they belong to
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_cu_clear  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (bus.abort && r_state != S_IDLE) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_cu_clear  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cu_clear <= bus.start;
          r_busy     <= bus.start;
          r_state    <= bus.start ? S_CLEAR : S_IDLE;
        end
        S_CLEAR: begin
          r_cu_clear <= 1'b0;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          r_out_valid <= w_term;
          r_state     <= w_term ? S_WRITE : S_RUN;
        end
        S_WRITE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_cu_clear  <= 1'b1;
          if (r_col == '0) begin
            r_col   <= NU_COL;
            r_state <= S_CLEAR;
          end else if (r_row < ROW_LAST) begin
            r_row   <= r_row + 1'b1;
            r_col   <= '0;
            r_state <= S_CLEAR;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done     <= 1'b0;
          r_cu_clear <= 1'b0;
          r_busy     <= 1'b0;
          r_row      <= '0;
          r_col      <= '0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end

  assign bus.row_number = r_row;
  assign bus.column     = r_col;
  assign bus.cu_clear   = r_cu_clear;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_idx    = {r_row, r_col != '0};
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: directed checks of the half-row schedule on default and small geometries
module tb_conv_sched;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b1;
  logic sel = 1'b0;
  int checks = 0;
  int failures = 0;

  conv_sched_if a_if ();
  conv_sched_if b_if ();

  assign a_if.start     = start & ~sel;
  assign a_if.abort     = abort;
  assign a_if.out_ready = out_ready;
  assign b_if.start     = start & sel;
  assign b_if.abort     = abort;
  assign b_if.out_ready = out_ready;

  conv_sched u_a (.clk(clk), .reset(reset), .bus(a_if));
  conv_sched #(.DATA_WIDTH(16), .D(2), .H(8), .W(8), .F(3)) u_b (.clk(clk), .reset(reset), .bus(b_if));

  logic       m_valid, m_clr, m_busy, m_done;
  logic [5:0] m_row, m_col;
  logic [6:0] m_idx;

  assign m_valid = sel ? b_if.out_valid  : a_if.out_valid;
  assign m_clr   = sel ? b_if.cu_clear   : a_if.cu_clear;
  assign m_busy  = sel ? b_if.busy       : a_if.busy;
  assign m_done  = sel ? b_if.done       : a_if.done;
  assign m_row   = sel ? b_if.row_number : a_if.row_number;
  assign m_col   = sel ? b_if.column     : a_if.column;
  assign m_idx   = sel ? b_if.out_idx    : a_if.out_idx;

  always #5 clk = ~clk;

  task automatic run_image(input int per, input int npass, input int nu,
                           input int stall_idx, input int stall_len, input bit spam);
    int t, p, waited, t_exp, t_done;
    bit fin, seen;
    logic [18:0] exp_pos;
    p = 0; waited = 0; fin = 0; seen = 0;
    t_done = per * npass + 1 + (stall_idx >= 0 ? stall_len : 0);
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; t = 1;
    checks++;
    if (m_clr !== 1'b1) begin failures++; $display("FAIL clear_first got=%b exp=1", m_clr); end
    while (!fin && t < t_done + 50) begin
      exp_pos = {6'(p / 2), (p % 2 == 1) ? 6'(nu) : 6'd0, 7'(p)};
      if (m_valid) begin
        if (!seen) begin
          t_exp = per * (p + 1) + ((stall_idx >= 0 && p > stall_idx) ? stall_len : 0);
          checks++;
          if (t !== t_exp) begin failures++; $display("FAIL valid_time pass=%0d got=%0d exp=%0d", p, t, t_exp); end
          checks++;
          if (m_clr !== 1'b0) begin failures++; $display("FAIL clr_in_write pass=%0d got=%b exp=0", p, m_clr); end
          seen = 1;
        end
        checks++;
        if ({m_row, m_col, m_idx} !== exp_pos) begin
          failures++;
          $display("FAIL position pass=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", p, m_row, m_col, m_idx,
                   exp_pos[18:13], exp_pos[12:7], exp_pos[6:0]);
        end
        if (p == stall_idx && waited < stall_len) begin
          out_ready = 1'b0;
          waited++;
        end else begin
          out_ready = 1'b1;
          p++;
          seen = 0;
        end
      end
      if (m_done) begin
        checks++;
        if (t !== t_done) begin failures++; $display("FAIL done_time got=%0d exp=%0d", t, t_done); end
        checks++;
        if (p !== npass) begin failures++; $display("FAIL pass_count got=%0d exp=%0d", p, npass); end
        fin = 1;
      end
      if (!fin) start = spam && (t % 37 == 5);
      @(negedge clk); t++;
    end
    start = 1'b0; out_ready = 1'b1;
    checks++;
    if (!fin) begin failures++; $display("FAIL timeout got=%0d exp=%0d", t, t_done); end
    checks++;
    if ({m_busy, m_done} !== 2'b00) begin failures++; $display("FAIL idle_after got=%b exp=00", {m_busy, m_done}); end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++;
    if ({m_clr, m_valid, m_busy, m_done} !== 4'b1000) begin
      failures++; $display("FAIL reset_flags got=%b exp=1000", {m_clr, m_valid, m_busy, m_done});
    end
    checks++;
    if ({m_row, m_col, m_idx} !== 19'd0) begin
      failures++; $display("FAIL reset_pos got=%0d/%0d/%0d exp=0/0/0", m_row, m_col, m_idx);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full();
    run_image(29, 56, 14, -1, 0, 0);
  endtask

  task automatic test_stall();
    run_image(29, 56, 14, 3, 10, 0);
  endtask

  task automatic test_abort();
    int n;
    bit hit, bad;
    hit = 0; bad = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (n = 0; n < 2000 && !hit; n++) begin
      if (m_idx == 7'd20 && m_busy && !m_clr && !m_valid) begin
        abort = 1'b1; hit = 1;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    checks++;
    if (!hit) begin failures++; $display("FAIL abort_reach got=0 exp=1"); end
    checks++;
    if ({m_busy, m_clr, m_valid, m_done} !== 4'b0100) begin
      failures++; $display("FAIL abort_flags got=%b exp=0100", {m_busy, m_clr, m_valid, m_done});
    end
    checks++;
    if (m_idx !== 7'd0) begin failures++; $display("FAIL abort_idx got=%0d exp=0", m_idx); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_done || m_busy) bad = 1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL abort_quiet got=1 exp=0"); end
    run_image(29, 56, 14, -1, 0, 0);
  endtask

  task automatic test_start_busy();
    run_image(29, 56, 14, -1, 0, 1);
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      if (m_valid && m_idx == 7'd5) begin out_ready = 1'b0; hit = 1; end
      @(negedge clk);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (!hit) begin failures++; $display("FAIL reset_reach got=0 exp=1"); end
    checks++;
    if ({m_clr, m_valid, m_busy, m_done} !== 4'b1000 || {m_row, m_col} !== 12'd0) begin
      failures++;
      $display("FAIL reset_mid got=%b/%0d/%0d exp=1000/0/0", {m_clr, m_valid, m_busy, m_done}, m_row, m_col);
    end
    @(negedge clk); reset = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    run_image(29, 56, 14, -1, 0, 0);
  endtask

  task automatic test_small();
    sel = 1'b1;
    @(negedge clk);
    run_image(22, 12, 3, -1, 0, 0);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full();
    test_stall();
    test_abort();
    test_start_busy();
    test_reset_mid();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
